// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one fixed-latency, single-op-in-flight multiplier
// between NUM_REQ requesters, holding each tagged result until the consumer takes it.
module mult_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MULT_LATENCY = 8,
    localparam int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    mult_clk_en,
    output logic [15:0]             mult_dataa,
    output logic [15:0]             mult_datab,
    input  logic [15:0]             mult_result,
    input  logic [2:0]              mult_flags,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [15:0]             rsp_result,
    output logic [2:0]              rsp_flags
);

    localparam int unsigned CNT_W = $clog2(MULT_LATENCY + 1);

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_id;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic [15:0]       sel_a;
    logic [15:0]       sel_b;

    // Round-robin search starting just after the most recent grant
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            int unsigned idx;
            idx = (32'(last_grant) + i) % NUM_REQ;
            if (!pick_found && req_valid[ID_W'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == pick_id) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_DRAIN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_DRAIN: if (cnt == '0) state_next = S_IDLE;
            S_IDLE:  if (pick_found) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (cnt == '0) state_next = S_RESP;
            S_RESP:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_DRAIN;
        endcase
    end

    // Grant is combinational so the handshake completes in the same IDLE cycle
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && pick_found) begin
            req_ready[pick_id] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= CNT_W'(MULT_LATENCY);
            last_grant  <= ID_W'(NUM_REQ - 1);
            grant_id    <= '0;
            mult_clk_en <= 1'b0;
            mult_dataa  <= '0;
            mult_datab  <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
        end else begin
            mult_clk_en <= (state_next == S_ISSUE);
            rsp_valid   <= (state_next == S_RESP);
            case (state)
                S_DRAIN: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                S_IDLE: begin
                    if (pick_found) begin
                        grant_id   <= pick_id;
                        last_grant <= pick_id;
                        mult_dataa <= sel_a;
                        mult_datab <= sel_b;
                    end
                end
                S_ISSUE: begin
                    cnt <= CNT_W'(MULT_LATENCY - 1);
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        rsp_id     <= grant_id;
                        rsp_result <= mult_result;
                        rsp_flags  <= mult_flags;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios plus random traffic, checked each cycle
// against a timeline model of grant / issue / response events.
module tb_mult_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned LAT  = 8;
    localparam int unsigned ID_W = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0]        req_valid = '0;
    logic [16*N-1:0]     req_a = '0;
    logic [16*N-1:0]     req_b = '0;
    logic [N-1:0]        req_ready;
    logic                mult_clk_en;
    logic [15:0]         mult_dataa;
    logic [15:0]         mult_datab;
    logic [15:0]         mult_result = 16'h0000;
    logic [2:0]          mult_flags = 3'b000;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [ID_W-1:0]     rsp_id;
    logic [15:0]         rsp_result;
    logic [2:0]          rsp_flags;

    mult_arbiter #(.NUM_REQ(N), .MULT_LATENCY(LAT)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .mult_clk_en (mult_clk_en),
        .mult_dataa  (mult_dataa),
        .mult_datab  (mult_datab),
        .mult_result (mult_result),
        .mult_flags  (mult_flags),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags)
    );

    always #5 clock = ~clock;

    // Multiplier stand-in: {flags, result}; exact for the unit and inf*0 cases
    function automatic logic [18:0] mult_fn(input logic [15:0] a, input logic [15:0] b);
        if ((a == 16'h7C00 && b == 16'h0000) || (b == 16'h7C00 && a == 16'h0000))
            return {3'b100, 16'h7E00};
        if (a == 16'h3C00) return {3'b000, b};
        if (b == 16'h3C00) return {3'b000, a};
        return {a[2:0] ^ b[5:3], a ^ {b[7:0], b[15:8]} ^ 16'h1234};
    endfunction

    // Result is junk while in flight and settles before the arbiter's capture edge
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    int          m_left = 0;
    always @(posedge clock) begin
        if (mult_clk_en) begin
            op_a        <= mult_dataa;
            op_b        <= mult_datab;
            m_left      <= int'(LAT) - 1;
            mult_result <= 16'hDEAD;
            mult_flags  <= 3'b111;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) {mult_flags, mult_result} <= mult_fn(op_a, op_b);
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Timeline model: cycle numbers of grant, issue and response visibility
    int             cyc = 0;
    int             ready_at = 0;
    int             acc = 0;
    int             last_g = int'(N) - 1;
    int             hs_id = -1;
    bit             in_flight = 1'b0;
    logic [15:0]    e_da = '0;
    logic [15:0]    e_db = '0;
    logic [15:0]    e_res = '0;
    logic [2:0]     e_flags = '0;
    logic [ID_W-1:0] e_id = '0;
    logic [18:0]    pend = '0;
    int             pend_id = 0;
    logic [N-1:0]   e_ready = '0;
    bit             e_clk_en = 1'b0;
    bit             e_rsp_valid = 1'b0;

    int             g_id[$];
    int             g_cyc[$];
    int             rv_cyc[$];
    int             rv_id[$];
    logic [18:0]    rv_data[$];
    int             n_clk_en = 0;
    int             rel = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        g_id.delete();
        g_cyc.delete();
        rv_cyc.delete();
        rv_id.delete();
        rv_data.delete();
        n_clk_en = 0;
    endtask

    task automatic check_cycle();
        @(negedge clock);
        e_ready = '0;
        if (!reset && !in_flight && cyc >= ready_at) begin
            for (int i = 1; i <= int'(N); i++) begin
                int k;
                k = (last_g + i) % int'(N);
                if (req_valid[k]) begin
                    e_ready[k] = 1'b1;
                    break;
                end
            end
        end
        e_clk_en    = in_flight && (cyc == acc + 1);
        e_rsp_valid = in_flight && (cyc >= acc + int'(LAT) + 2);
        chk("req_ready",   32'(req_ready),   32'(e_ready));
        chk("mult_clk_en", 32'(mult_clk_en), 32'(e_clk_en));
        chk("mult_dataa",  32'(mult_dataa),  32'(e_da));
        chk("mult_datab",  32'(mult_datab),  32'(e_db));
        chk("rsp_valid",   32'(rsp_valid),   32'(e_rsp_valid));
        chk("rsp_id",      32'(rsp_id),      32'(e_id));
        chk("rsp_result",  32'(rsp_result),  32'(e_res));
        chk("rsp_flags",   32'(rsp_flags),   32'(e_flags));
        for (int i = 0; i < int'(N); i++) begin
            if (req_ready[i]) begin
                g_id.push_back(i);
                g_cyc.push_back(cyc);
            end
        end
        if (mult_clk_en) n_clk_en++;
        if (rsp_valid && rsp_ready) begin
            rv_cyc.push_back(cyc);
            rv_id.push_back(int'(rsp_id));
            rv_data.push_back({rsp_flags, rsp_result});
        end
    endtask

    task automatic tick();
        @(posedge clock);
        hs_id = -1;
        if (e_rsp_valid && rsp_ready) begin
            in_flight = 1'b0;
            ready_at  = cyc + 1;
        end
        for (int i = 0; i < int'(N); i++) begin
            if (e_ready[i]) begin
                hs_id     = i;
                in_flight = 1'b1;
                acc       = cyc;
                last_g    = i;
                e_da      = req_a[16*i +: 16];
                e_db      = req_b[16*i +: 16];
                pend      = mult_fn(e_da, e_db);
                pend_id   = i;
            end
        end
        cyc++;
        if (in_flight && cyc == acc + int'(LAT) + 2) begin
            {e_flags, e_res} = pend;
            e_id = ID_W'(pend_id);
        end
        #1;
    endtask

    task automatic cycle();
        check_cycle();
        tick();
    endtask

    task automatic apply_reset(input int n);
        reset     = 1'b1;
        in_flight = 1'b0;
        last_g    = int'(N) - 1;
        e_da = '0; e_db = '0; e_res = '0; e_flags = '0; e_id = '0;
        ready_at  = cyc + 1000000;
        repeat (n) cycle();
        reset     = 1'b0;
        ready_at  = cyc + int'(LAT) + 1;
        rel       = cyc;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic rand_op(input int i);
        set_op(i, 16'($urandom), 16'($urandom));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        // 1: single request, drain window after reset, unit multiply
        apply_reset(3);
        clear_logs();
        set_op(0, 16'h3C00, 16'h4000);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        for (int t = 0; t < 20 && g_id.size() == 0; t++) cycle();
        req_valid = '0;
        run(12);
        chk("t1_grant_id",    32'(g_id[0]), 0);
        chk("t1_drain_len",   32'(g_cyc[0] - rel), 32'(LAT + 1));
        chk("t1_clk_en_cnt",  32'(n_clk_en), 1);
        chk("t1_latency",     32'(rv_cyc[0] - g_cyc[0]), 32'(LAT + 2));
        chk("t1_rsp_id",      32'(rv_id[0]), 0);
        chk("t1_rsp_data",    32'(rv_data[0]), 32'({3'b000, 16'h4000}));

        // 2: all requesters valid, consumer always ready
        apply_reset(2);
        clear_logs();
        for (int i = 0; i < int'(N); i++) rand_op(i);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int t = 0; t < 80 && g_id.size() < 5; t++) begin
            cycle();
            if (hs_id >= 0) rand_op(hs_id);
        end
        req_valid = '0;
        run(12);
        for (int k = 0; k < 5; k++) chk("t2_order", 32'(g_id[k]), 32'(k % 4));
        for (int k = 0; k < 4; k++) chk("t2_spacing", 32'(g_cyc[k+1] - g_cyc[k]), 32'(LAT + 3));
        for (int k = 0; k < 5; k++) chk("t2_rsp_id", 32'(rv_id[k]), 32'(k % 4));

        // 3: consumer stalls 20 cycles in response
        clear_logs();
        rsp_ready = 1'b0;
        rand_op(1);
        rand_op(2);
        req_valid = 4'b0010;
        for (int t = 0; t < 20 && g_id.size() == 0; t++) cycle();
        req_valid = 4'b0100;
        for (int t = 0; t < 20 && !rsp_valid; t++) cycle();
        chk("t3_rsp_seen", 32'(rsp_valid), 1);
        run(20);
        rsp_ready = 1'b1;
        for (int t = 0; t < 20 && g_id.size() < 2; t++) begin
            cycle();
            if (hs_id >= 0) req_valid = '0;
        end
        run(12);
        chk("t3_second_grant", 32'(g_id[1]), 2);
        chk("t3_grant_after_accept", 32'(g_cyc[1] - rv_cyc[0]), 1);

        // 4: last grant was 2; requesters 0 and 2 competing
        clear_logs();
        rand_op(0);
        rand_op(2);
        req_valid = 4'b0101;
        for (int t = 0; t < 40 && g_id.size() < 2; t++) begin
            cycle();
            if (hs_id >= 0) rand_op(hs_id);
        end
        req_valid = '0;
        run(12);
        chk("t4_first",  32'(g_id[0]), 0);
        chk("t4_second", 32'(g_id[1]), 2);

        // 5: reset lands mid-operation
        clear_logs();
        rand_op(3);
        req_valid = 4'b1000;
        for (int t = 0; t < 20 && !mult_clk_en; t++) cycle();
        chk("t5_issue_seen", 32'(mult_clk_en), 1);
        req_valid = '0;
        run(3);
        req_valid = '1;
        clear_logs();
        apply_reset(2);
        for (int t = 0; t < 30 && g_id.size() == 0; t++) cycle();
        chk("t5_no_early_grant", 32'(g_cyc[0] - rel >= int'(LAT) + 1), 1);
        chk("t5_no_stale_rsp",   32'(rv_cyc.size()), 0);
        req_valid = '0;
        run(12);

        // 6: inf * 0 produces NaN flag
        clear_logs();
        set_op(1, 16'h7C00, 16'h0000);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        for (int t = 0; t < 20 && g_id.size() == 0; t++) cycle();
        req_valid = '0;
        run(12);
        chk("t6_rsp_id",   32'(rv_id[0]), 1);
        chk("t6_rsp_data", 32'(rv_data[0]), 32'({3'b100, 16'h7E00}));

        // 7: random traffic with legal operand holding and one mid-run reset
        for (int t = 0; t < 800; t++) begin
            if (t == 400) apply_reset(2);
            cycle();
            for (int i = 0; i < int'(N); i++) begin
                if (hs_id == i) begin
                    rand_op(i);
                    req_valid[i] = 1'($urandom_range(0, 1));
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        if ($urandom_range(0, 4) == 0) set_op(i, 16'h3C00, 16'($urandom));
                        else rand_op(i);
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
